// File: rtl/voice_sequencer_pkg.sv
// Shared definitions for the voice sequencer: frame FSM states, mix width
// derivation and the one-hot channel decoder.
package voice_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Upper bound on voice count supported by the shared one-hot decoder.
    localparam int MAX_CHANNELS = 256;
    localparam int MAX_IDX_W    = 8;

    function automatic int mix_width(input int width, input int num_channels);
        return width + $clog2(num_channels);
    endfunction

    function automatic logic [MAX_CHANNELS-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_CHANNELS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/voice_tag_pipe.sv
// Delay line that carries the "this slot belongs to an active voice" bit
// alongside the note generator latency.
module voice_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    output logic o_valid
);

    logic [DEPTH-1:0] r_pipe;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_valid = r_pipe[DEPTH-1];

endmodule

// File: rtl/voice_sequencer.sv
// Time-multiplexes one note generator across NUM_CHANNELS voices and mixes
// the returned samples into one output sample per sample_tick.
module voice_sequencer
    import voice_sequencer_pkg::*;
#(
    parameter int NUM_CHANNELS = 16,
    parameter int NUM_BITS     = 32,
    parameter int WIDTH        = 18,
    parameter int GEN_LAT      = 2,
    parameter int MIX_WIDTH    = mix_width(WIDTH, NUM_CHANNELS),
    localparam int CH_W        = $clog2(NUM_CHANNELS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_sample_tick,
    input  logic                    i_note_on,
    input  logic                    i_note_off,
    input  logic [CH_W-1:0]         i_note_idx,
    input  logic [NUM_BITS-1:0]     i_note_tw,
    output logic [NUM_CHANNELS-1:0] o_acc_en,
    output logic [NUM_CHANNELS-1:0] o_acc_clr,
    output logic [NUM_CHANNELS-1:0] o_curr_note,
    output logic [NUM_BITS-1:0]     o_tuning_word,
    input  logic [WIDTH-1:0]        i_wave_in,
    output logic [MIX_WIDTH-1:0]    o_mix_out,
    output logic                    o_mix_valid,
    output logic [NUM_CHANNELS-1:0] o_active_mask,
    output logic                    o_overrun
);

    localparam int DRAIN_W = $clog2(GEN_LAT + 1);

    seq_state_t              r_state;
    logic [CH_W-1:0]         r_ch;
    logic [DRAIN_W-1:0]      r_drain_cnt;
    logic [NUM_CHANNELS-1:0] r_frame_mask;
    logic [NUM_CHANNELS-1:0] r_active;
    logic [NUM_CHANNELS-1:0] r_pending_clr;
    logic [NUM_CHANNELS-1:0] r_acc_en;
    logic [NUM_CHANNELS-1:0] r_curr_note;
    logic [NUM_BITS-1:0]     r_tw [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     r_tuning_word;
    logic [MIX_WIDTH-1:0]    r_acc;
    logic [MIX_WIDTH-1:0]    r_mix_out;
    logic                    r_mix_valid;
    logic                    r_overrun;

    logic [NUM_CHANNELS-1:0] w_idx_onehot;
    logic [CH_W-1:0]         w_load_ch;
    logic [NUM_CHANNELS-1:0] w_load_sel;
    logic                    w_load_active;
    logic [NUM_BITS-1:0]     w_load_tw;
    logic                    w_tag_valid;
    logic [MIX_WIDTH-1:0]    w_wave_ext;
    logic [MIX_WIDTH-1:0]    w_acc_next;

    assign w_idx_onehot = NUM_CHANNELS'(onehot(MAX_IDX_W'(i_note_idx)));

    // Generator outputs are registered, so the voice presented next cycle is
    // chosen here: voice 0 when a frame starts, otherwise the following voice.
    assign w_load_ch     = (r_state == IDLE) ? '0 : r_ch + CH_W'(1);
    assign w_load_sel    = NUM_CHANNELS'(onehot(MAX_IDX_W'(w_load_ch)));
    assign w_load_active = (r_state == IDLE) ? r_active[w_load_ch] : r_frame_mask[w_load_ch];
    assign w_load_tw     = (i_note_on && (i_note_idx == w_load_ch)) ? i_note_tw : r_tw[w_load_ch];

    assign w_wave_ext = {{(MIX_WIDTH-WIDTH){i_wave_in[WIDTH-1]}}, i_wave_in};
    assign w_acc_next = w_tag_valid ? (r_acc + w_wave_ext) : r_acc;

    voice_tag_pipe #(
        .DEPTH(GEN_LAT)
    ) u_tag_pipe (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(|r_acc_en),
        .o_valid(w_tag_valid)
    );

    // Note event table; phase clears are held until an IDLE cycle so they
    // never coincide with an accumulate enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_tw[i] <= '0;
            end
            r_active      <= '0;
            r_pending_clr <= '0;
        end else begin
            if (i_note_on) begin
                r_tw[i_note_idx] <= i_note_tw;
                r_active         <= r_active | w_idx_onehot;
            end else if (i_note_off) begin
                r_active <= r_active & ~w_idx_onehot;
            end
            r_pending_clr <= ((r_state == IDLE) ? '0 : r_pending_clr)
                           | (i_note_on ? w_idx_onehot : '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_ch          <= '0;
            r_drain_cnt   <= '0;
            r_frame_mask  <= '0;
            r_acc_en      <= '0;
            r_curr_note   <= '0;
            r_tuning_word <= '0;
            r_acc         <= '0;
            r_mix_out     <= '0;
            r_mix_valid   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_mix_valid <= 1'b0;
            if (i_sample_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (i_sample_tick) begin
                        r_state       <= SCAN;
                        r_ch          <= '0;
                        r_acc         <= '0;
                        r_frame_mask  <= r_active;
                        r_curr_note   <= w_load_sel;
                        r_acc_en      <= w_load_active ? w_load_sel : '0;
                        r_tuning_word <= w_load_tw;
                    end
                end
                SCAN: begin
                    r_acc <= w_acc_next;
                    if (r_ch == CH_W'(NUM_CHANNELS - 1)) begin
                        r_state       <= DRAIN;
                        r_drain_cnt   <= '0;
                        r_curr_note   <= '0;
                        r_acc_en      <= '0;
                        r_tuning_word <= '0;
                    end else begin
                        r_ch          <= w_load_ch;
                        r_curr_note   <= w_load_sel;
                        r_acc_en      <= w_load_active ? w_load_sel : '0;
                        r_tuning_word <= w_load_tw;
                    end
                end
                DRAIN: begin
                    r_acc <= w_acc_next;
                    // The last drain cycle folds in the final voice directly.
                    if (r_drain_cnt == DRAIN_W'(GEN_LAT - 1)) begin
                        r_state     <= DONE;
                        r_mix_out   <= w_acc_next;
                        r_mix_valid <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_acc_clr     = (r_state == IDLE) ? r_pending_clr : '0;
    assign o_acc_en      = r_acc_en;
    assign o_curr_note   = r_curr_note;
    assign o_tuning_word = r_tuning_word;
    assign o_mix_out     = r_mix_out;
    assign o_mix_valid   = r_mix_valid;
    assign o_active_mask = r_active;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer with a two-cycle generator stub and a
// scoreboard of expected mixes checked whenever mix_valid fires.
module tb_voice_sequencer;

    localparam int NCH = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        tick      = 1'b0;
    logic        noteOn    = 1'b0;
    logic        noteOff   = 1'b0;
    logic [3:0]  noteIdx   = '0;
    logic [31:0] noteTw    = '0;
    logic [15:0] accEn;
    logic [15:0] accClr;
    logic [15:0] currNote;
    logic [31:0] tuningWord;
    logic [17:0] waveIn;
    logic [21:0] mixOut;
    logic        mixValid;
    logic [15:0] activeMask;
    logic        overrun;

    logic [17:0] voiceVal [NCH];
    logic [15:0] selD1 = '0;
    logic [15:0] selD2 = '0;

    int cyc     = 0;
    int nChecks = 0;
    int nFail   = 0;
    int tStart;

    typedef struct {
        int          cyc;
        logic [21:0] val;
    } exp_t;
    exp_t expQ[$];

    voice_sequencer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_sample_tick(tick),
        .i_note_on    (noteOn),
        .i_note_off   (noteOff),
        .i_note_idx   (noteIdx),
        .i_note_tw    (noteTw),
        .o_acc_en     (accEn),
        .o_acc_clr    (accClr),
        .o_curr_note  (currNote),
        .o_tuning_word(tuningWord),
        .i_wave_in    (waveIn),
        .o_mix_out    (mixOut),
        .o_mix_valid  (mixValid),
        .o_active_mask(activeMask),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Generator stub: a voice's constant appears two cycles after selection.
    always @(posedge clk) begin
        selD1 <= currNote;
        selD2 <= selD1;
    end

    always_comb begin
        waveIn = '0;
        for (int i = 0; i < NCH; i++) begin
            if (selD2[i]) waveIn = voiceVal[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mixValid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious mix_valid", {63'b0, mixValid}, 64'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("mix_valid cycle", 64'(cyc), 64'(e.cyc));
                checkOutput("mix_out", 64'($signed(mixOut)), 64'($signed(e.val)));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic on, input logic off, input logic [3:0] idx,
                                 input logic [31:0] tw);
        noteOn  = on;
        noteOff = off;
        noteIdx = idx;
        noteTw  = tw;
        step();
        noteOn  = 1'b0;
        noteOff = 1'b0;
    endtask

    task automatic startFrame(input logic [21:0] expVal);
        tStart = cyc;
        expQ.push_back('{tStart + 19, expVal});
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic waitFrame();
        for (int i = 0; i < 40 && expQ.size() != 0; i++) step();
        checkOutput("frame completes", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) voiceVal[i] = '0;
        step();
        step();
        checkOutput("reset active_mask", 64'(activeMask), 64'd0);
        checkOutput("reset mix_valid", {63'b0, mixValid}, 64'd0);
        checkOutput("reset overrun", {63'b0, overrun}, 64'd0);
        rst_n = 1'b1;
        step();

        // note_on to voice 3: one-cycle phase clear, tuning word during its scan slot
        applyStimulus(1'b1, 1'b0, 4'd3, 32'h0100_0000);
        checkOutput("acc_clr after note_on", 64'(accClr), 64'h0008);
        checkOutput("active after note_on", 64'(activeMask), 64'h0008);
        step();
        checkOutput("acc_clr one cycle", 64'(accClr), 64'h0000);
        voiceVal[3] = 18'd7;
        startFrame(22'd7);
        step();
        step();
        step();
        checkOutput("curr_note voice3", 64'(currNote), 64'h0008);
        checkOutput("tuning_word voice3", 64'(tuningWord), 64'h0100_0000);
        checkOutput("acc_en voice3", 64'(accEn), 64'h0008);
        waitFrame();
        applyStimulus(1'b0, 1'b1, 4'd3, 32'h0);

        // voices 0 and 5: per-cycle acc_en profile and signed mix
        voiceVal[0] = 18'd100;
        voiceVal[5] = 18'(-50);
        applyStimulus(1'b1, 1'b0, 4'd0, 32'h0000_1000);
        applyStimulus(1'b1, 1'b0, 4'd5, 32'h0000_5000);
        checkOutput("active voices 0,5", 64'(activeMask), 64'h0021);
        tStart = cyc;
        expQ.push_back('{tStart + 19, 22'd50});
        tick = 1'b1;
        for (int c = 0; c < 20; c++) begin
            checkOutput($sformatf("acc_en T+%0d", c), 64'(accEn),
                        (c == 1) ? 64'h0001 : (c == 6) ? 64'h0020 : 64'h0000);
            step();
            tick = 1'b0;
        end
        waitFrame();
        applyStimulus(1'b0, 1'b1, 4'd0, 32'h0);
        applyStimulus(1'b0, 1'b1, 4'd5, 32'h0);

        // full-scale mixes: all voices at max positive, then max negative
        for (int i = 0; i < NCH; i++) begin
            voiceVal[i] = 18'h1FFFF;
            applyStimulus(1'b1, 1'b0, 4'(i), 32'(i * 32'h0010_0000));
        end
        checkOutput("all voices active", 64'(activeMask), 64'hFFFF);
        startFrame(22'd2097136);
        waitFrame();
        for (int i = 0; i < NCH; i++) voiceVal[i] = 18'h20000;
        startFrame(22'h200000);
        waitFrame();

        // overrun: second tick mid-frame is dropped, flag is sticky
        for (int i = 0; i < NCH; i++) voiceVal[i] = 18'(i - 8);
        checkOutput("overrun before", {63'b0, overrun}, 64'd0);
        startFrame(22'(-8));
        for (int i = 0; i < 4; i++) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        checkOutput("overrun set", {63'b0, overrun}, 64'd1);
        waitFrame();
        for (int i = 0; i < 6; i++) step();
        checkOutput("overrun sticky", {63'b0, overrun}, 64'd1);

        // note_on beats note_off; note_off mid-scan affects only the next frame
        for (int i = 0; i < NCH; i++) applyStimulus(1'b0, 1'b1, 4'(i), 32'h0);
        checkOutput("all voices off", 64'(activeMask), 64'h0000);
        applyStimulus(1'b1, 1'b1, 4'd2, 32'h0200_0000);
        checkOutput("note_on wins", 64'(activeMask), 64'h0004);
        applyStimulus(1'b1, 1'b0, 4'd9, 32'h0300_0000);
        voiceVal[2] = 18'd1000;
        voiceVal[9] = 18'(-3);
        startFrame(22'd997);
        step();
        noteOff = 1'b1;
        noteIdx = 4'd2;
        step();
        noteOff = 1'b0;
        checkOutput("active after scan note_off", 64'(activeMask), 64'h0200);
        waitFrame();
        startFrame(22'(-3));
        waitFrame();

        // asynchronous reset mid-frame
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        #1;
        checkOutput("rst acc_en", 64'(accEn), 64'h0);
        checkOutput("rst acc_clr", 64'(accClr), 64'h0);
        checkOutput("rst curr_note", 64'(currNote), 64'h0);
        checkOutput("rst tuning_word", 64'(tuningWord), 64'h0);
        checkOutput("rst mix_out", 64'(mixOut), 64'h0);
        checkOutput("rst mix_valid", {63'b0, mixValid}, 64'd0);
        checkOutput("rst active_mask", 64'(activeMask), 64'h0);
        checkOutput("rst overrun", {63'b0, overrun}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step();
        checkOutput("active after reset", 64'(activeMask), 64'h0);
        checkOutput("queue empty", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
